// File: rtl/apu_note_sequencer_pkg.sv
// Shared APU types: song table entry layout, sequencer states and the built-in default song.
package apu_note_sequencer_pkg;

  typedef struct packed {
    logic        rest;
    logic [15:0] period;
    logic [7:0]  duty;
    logic [7:0]  dur;
  } note_entry_t;

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, ADV, END} seq_state_t;

  // A zero duration terminates the song, so every unlisted index reads as end-of-song.
  function automatic note_entry_t song_rom(input int unsigned idx);
    note_entry_t e;
    e = '0;
    case (idx)
      0:       e = '{rest: 1'b0, period: 16'd12500, duty: 8'd128, dur: 8'd4};
      1:       e = '{rest: 1'b1, period: 16'd0,     duty: 8'd0,   dur: 8'd2};
      2:       e = '{rest: 1'b0, period: 16'd6250,  duty: 8'd64,  dur: 8'd3};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/apu_note_sequencer_if.sv
// Control/tone bus between top-level control (master) and the note sequencer (slave).
interface apu_note_sequencer_if #(
  parameter int IDX_W = 4
);
  logic             start;
  logic             stop;
  logic             loop_en;
  logic [15:0]      tone_period;
  logic [7:0]       tone_duty;
  logic             tone_en;
  logic [IDX_W-1:0] note_idx;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, loop_en,
    input  tone_period, tone_duty, tone_en, note_idx, busy, done
  );

  modport slave (
    input  start, stop, loop_en,
    output tone_period, tone_duty, tone_en, note_idx, busy, done
  );
endinterface

// File: rtl/apu_note_sequencer_tick_gen.sv
// Duration prescaler: counts 0..TICK_CYC-1 and flags the terminal count; clr_i holds it at 0.
module apu_note_sequencer_tick_gen #(
  parameter int TICK_CYC = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CNT_W = $clog2(TICK_CYC);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = (cnt_q == CNT_W'(TICK_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/apu_note_sequencer.sv
// Steps through the song table, timing each note and the silent gap after it in prescaled
// ticks, and drives the registered tone controls for the PWM stage.
module apu_note_sequencer
  import apu_note_sequencer_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int SONG_LEN   = 16,
  parameter int GAP_TICKS  = 10,
  parameter bit EMPTY_SONG = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  apu_note_sequencer_if.slave ctrl
);
  localparam int TICK_CYC = CLK_HZ / TICK_HZ;
  localparam int IDX_W    = $clog2(SONG_LEN);
  // One extra index bit so the walk can reach SONG_LEN and stop there.
  localparam logic [IDX_W:0] LAST_IDX = (IDX_W + 1)'(SONG_LEN);

  seq_state_t     state_q;
  logic [IDX_W:0] idx_q;
  logic [7:0]     durCnt_q;
  logic [15:0]    tonePeriod_q;
  logic [7:0]     toneDuty_q;
  logic           toneEn_q;
  logic           busy_q;
  logic           done_q;

  note_entry_t entry;
  logic        songEnd;
  logic        tick;
  logic        prescaleClr;

  assign entry       = (EMPTY_SONG && idx_q == '0) ? '0 : song_rom(32'(idx_q));
  assign songEnd     = (entry.dur == 8'd0) || (idx_q == LAST_IDX);
  assign prescaleClr = (state_q != PLAY) && (state_q != GAP);

  apu_note_sequencer_tick_gen #(.TICK_CYC(TICK_CYC)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (prescaleClr),
    .tick_o (tick)
  );

  // durCnt_q counts the note length in PLAY and is reloaded with the gap length for GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      durCnt_q     <= '0;
      tonePeriod_q <= '0;
      toneDuty_q   <= '0;
      toneEn_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ctrl.stop) begin
        state_q  <= IDLE;
        idx_q    <= '0;
        durCnt_q <= '0;
        toneEn_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (ctrl.start) begin
              state_q <= FETCH;
              idx_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          FETCH: begin
            if (songEnd) begin
              state_q <= END;
            end else begin
              tonePeriod_q <= entry.period;
              toneDuty_q   <= entry.duty;
              toneEn_q     <= !entry.rest;
              durCnt_q     <= entry.dur;
              state_q      <= PLAY;
            end
          end
          PLAY: begin
            if (tick) begin
              durCnt_q <= durCnt_q - 1'b1;
              if (durCnt_q == 8'd1) begin
                toneEn_q <= 1'b0;
                if (GAP_TICKS > 0) begin
                  durCnt_q <= 8'(GAP_TICKS);
                  state_q  <= GAP;
                end else begin
                  state_q <= ADV;
                end
              end
            end
          end
          GAP: begin
            if (tick) begin
              durCnt_q <= durCnt_q - 1'b1;
              if (durCnt_q == 8'd1) begin
                state_q <= ADV;
              end
            end
          end
          ADV: begin
            idx_q   <= idx_q + 1'b1;
            state_q <= FETCH;
          end
          END: begin
            // Looping an empty song would spin forever, so index 0 always finishes.
            if (ctrl.loop_en && idx_q != '0) begin
              idx_q   <= '0;
              state_q <= FETCH;
            end else begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ctrl.tone_period = tonePeriod_q;
  assign ctrl.tone_duty   = toneDuty_q;
  assign ctrl.tone_en     = toneEn_q;
  assign ctrl.note_idx    = idx_q[IDX_W-1:0];
  assign ctrl.busy        = busy_q;
  assign ctrl.done        = done_q;
endmodule

// File: tb/tb_apu_note_sequencer.sv
// Scoreboard bench for apu_note_sequencer: a per-cycle expected output timeline is queued
// from the song table and timing constants, then popped and compared every cycle.
module tb_apu_note_sequencer;
  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int TICK_CYC  = CLK_HZ / TICK_HZ;
  localparam int GAP_TICKS = 1;
  localparam int SONG_LEN  = 16;
  localparam int IDX_W     = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  apu_note_sequencer_if #(.IDX_W(IDX_W)) bus ();
  apu_note_sequencer_if #(.IDX_W(IDX_W)) emptyBus ();

  apu_note_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SONG_LEN(SONG_LEN), .GAP_TICKS(GAP_TICKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  apu_note_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SONG_LEN(SONG_LEN), .GAP_TICKS(GAP_TICKS),
    .EMPTY_SONG(1'b1)
  ) dutEmpty (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (emptyBus)
  );

  int songPer  [3] = '{12500, 0, 6250};
  int songDuty [3] = '{128, 0, 64};
  int songDur  [3] = '{4, 2, 3};
  bit songRest [3] = '{1'b0, 1'b1, 1'b0};

  int          total = 0;
  int          bad   = 0;
  logic [31:0] expQ[$];
  string       tagQ[$];
  logic [15:0] lastPer  = '0;
  logic [7:0]  lastDuty = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observed();
    return {1'b0, bus.tone_en, bus.tone_period, bus.tone_duty, bus.note_idx, bus.busy, bus.done};
  endfunction

  function automatic logic [31:0] observedEmpty();
    return {29'b0, emptyBus.tone_en, emptyBus.busy, emptyBus.done};
  endfunction

  task automatic pushExp(input int n, input string tag, input bit en, input int idx,
                         input bit busy, input bit done);
    for (int i = 0; i < n; i++) begin
      expQ.push_back({1'b0, en, lastPer, lastDuty, 4'(idx), busy, done});
      tagQ.push_back(tag);
    end
  endtask

  // Timeline from the FETCH of entry 0 through the END cycle of the default song.
  task automatic pushSongBody();
    for (int e = 0; e < 3; e++) begin
      pushExp(1, $sformatf("fetch%0d", e), 1'b0, e, 1'b1, 1'b0);
      lastPer  = 16'(songPer[e]);
      lastDuty = 8'(songDuty[e]);
      pushExp(songDur[e] * TICK_CYC, $sformatf("play%0d", e), !songRest[e], e, 1'b1, 1'b0);
      pushExp(GAP_TICKS * TICK_CYC, $sformatf("gap%0d", e), 1'b0, e, 1'b1, 1'b0);
      pushExp(1, $sformatf("adv%0d", e), 1'b0, e, 1'b1, 1'b0);
    end
    pushExp(1, "fetchEnd", 1'b0, 3, 1'b1, 1'b0);
    pushExp(1, "end", 1'b0, 3, 1'b1, 1'b0);
  endtask

  // One compare per queued cycle; inputs for step k are sampled at the edge ending step k.
  task automatic applyStimulus(input int startAt, input int stopAt, input int extraA,
                               input int extraB, input bit loop);
    int n;
    n = expQ.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput(tagQ.pop_front(), observed(), expQ.pop_front());
      bus.start   = (k == startAt) || (k == extraA) || (k == extraB);
      bus.stop    = (k == stopAt);
      bus.loop_en = loop;
    end
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.loop_en      = 1'b0;
    emptyBus.start   = 1'b0;
    emptyBus.stop    = 1'b0;
    emptyBus.loop_en = 1'b1;

    #2 rst_n = 1'b0;
    #1 checkOutput("resetState", observed(), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Full song without looping; extra starts in PLAY and END must change nothing.
    pushExp(1, "idle", 1'b0, 0, 1'b0, 1'b0);
    pushSongBody();
    pushExp(1, "donePulse", 1'b0, 3, 1'b0, 1'b1);
    pushExp(2, "idleAfterDone", 1'b0, 3, 1'b0, 1'b0);
    applyStimulus(0, -1, 5, 128, 1'b0);

    // Looping: after END the song restarts at entry 0 with no done pulse, then stop.
    pushExp(1, "idleLoop", 1'b0, 3, 1'b0, 1'b0);
    pushSongBody();
    pushExp(1, "refetch", 1'b0, 0, 1'b1, 1'b0);
    lastPer  = 16'd12500;
    lastDuty = 8'd128;
    pushExp(10, "replay", 1'b1, 0, 1'b1, 1'b0);
    pushExp(3, "loopStopped", 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(0, 139, -1, -1, 1'b1);

    // Stop during entry 0, then stop and start together from IDLE.
    pushExp(1, "idleStop", 1'b0, 0, 1'b0, 1'b0);
    pushExp(1, "fetchStop", 1'b0, 0, 1'b1, 1'b0);
    pushExp(5, "playStop", 1'b1, 0, 1'b1, 1'b0);
    pushExp(3, "stopped", 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(0, 6, -1, -1, 1'b0);
    pushExp(4, "stopStart", 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(0, 0, -1, -1, 1'b0);

    // Asynchronous reset in the middle of a note.
    pushExp(1, "idleRst", 1'b0, 0, 1'b0, 1'b0);
    pushExp(1, "fetchRst", 1'b0, 0, 1'b1, 1'b0);
    pushExp(20, "playRst", 1'b1, 0, 1'b1, 1'b0);
    applyStimulus(0, -1, -1, -1, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("asyncReset", observed(), 32'h0);
    @(negedge clk);
    checkOutput("heldInReset", observed(), 32'h0);
    rst_n    = 1'b1;
    lastPer  = '0;
    lastDuty = '0;
    pushExp(3, "postReset", 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(-1, -1, -1, -1, 1'b0);

    // Playback still works after reset.
    pushExp(1, "idleRestart", 1'b0, 0, 1'b0, 1'b0);
    pushExp(1, "fetchRestart", 1'b0, 0, 1'b1, 1'b0);
    lastPer  = 16'd12500;
    lastDuty = 8'd128;
    pushExp(3, "playRestart", 1'b1, 0, 1'b1, 1'b0);
    pushExp(2, "stopRestart", 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(0, 4, -1, -1, 1'b0);

    // Empty table with loop_en=1: FETCH, END, then a single done and back to IDLE.
    @(negedge clk);
    checkOutput("emptyIdle", observedEmpty(), 32'b000);
    emptyBus.start = 1'b1;
    @(negedge clk);
    emptyBus.start = 1'b0;
    checkOutput("emptyFetch", observedEmpty(), 32'b010);
    @(negedge clk);
    checkOutput("emptyEnd", observedEmpty(), 32'b010);
    @(negedge clk);
    checkOutput("emptyDone", observedEmpty(), 32'b001);
    @(negedge clk);
    checkOutput("emptyBackIdle", observedEmpty(), 32'b000);
    @(negedge clk);
    checkOutput("emptyNoRelaunch", observedEmpty(), 32'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
